// File: rtl/read_response_fifo.sv
// Read-return buffer between the DRAM backend channel and the frontend.
// A read may issue only when a buffer slot is reserved for its data.
// Returned beats leave in arrival order. Sticky flags record unsolicited beats and stalls.
module read_response_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  ret_valid,
  input  logic [ID_WIDTH-1:0]   ret_id,
  input  logic [DATA_WIDTH-1:0] ret_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_WIDTH-1:0]   resp_id,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  read_pending,
  output logic                  empty,
  output logic                  unsol_err,
  output logic                  timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = PTR_W + 2;
  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  WD_ZERO   = {WD_W{1'b0}};
  localparam logic [WD_W-1:0]  WD_ONE    = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT);
  localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(DEPTH);

  // DEPTH is a power of two, so the natural binary wrap lands on slot 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_ONE;
  endfunction

  logic [ID_WIDTH-1:0]   id_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             unsol_err_q, unsol_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic [SUM_W-1:0] credit_sum;
  logic             issue_fire;
  logic             ret_accept;
  logic             ret_unsol;
  logic             pop;

  assign credit_sum   = SUM_W'(count_q) + SUM_W'(outstanding_q);
  assign issue_ready  = (credit_sum < SUM_DEPTH);
  assign resp_valid   = (count_q != CNT_ZERO);
  assign empty        = (count_q == CNT_ZERO);
  assign read_pending = (outstanding_q != CNT_ZERO);
  assign resp_id      = id_mem_q[rd_ptr_q];
  assign resp_data    = data_mem_q[rd_ptr_q];
  assign unsol_err    = unsol_err_q;
  assign timeout_err  = timeout_err_q;

  // Next-state for pointers, occupancy, credits, watchdog and error flags.
  always_comb begin
    issue_fire    = issue_valid & issue_ready;
    ret_accept    = ret_valid & (outstanding_q != CNT_ZERO);
    ret_unsol     = ret_valid & (outstanding_q == CNT_ZERO);
    pop           = resp_valid & resp_ready;

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    wd_cnt_d      = wd_cnt_q;
    unsol_err_d   = unsol_err_q | ret_unsol;
    timeout_err_d = timeout_err_q |
                    ((wd_cnt_q == WD_LIMIT) && (outstanding_q != CNT_ZERO));

    if (ret_accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({ret_accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case ({issue_fire, ret_accept})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    // Watchdog measures time since the last return while reads are in flight.
    if ((outstanding_q == CNT_ZERO) || ret_accept) begin
      wd_cnt_d = WD_ZERO;
    end else if (wd_cnt_q != WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + WD_ONE;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
      outstanding_q <= CNT_ZERO;
      wd_cnt_q      <= WD_ZERO;
      unsol_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      wd_cnt_q      <= wd_cnt_d;
      unsol_err_q   <= unsol_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Beat storage; contents are don't-care after reset, so no reset is applied.
  always_ff @(posedge clk) begin
    if (!rst && ret_accept) begin
      id_mem_q[wr_ptr_q]   <= ret_id;
      data_mem_q[wr_ptr_q] <= ret_data;
    end
  end

endmodule

// File: tb/tb_read_response_fifo.sv
// Directed, table-driven bench for read_response_fifo (DEPTH=4, TIMEOUT=15).
// Each record holds one cycle of stimulus and the outputs expected after that edge.
module tb_read_response_fifo;

  localparam int DW      = 128;
  localparam int IW      = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic          ret_valid;
  logic [IW-1:0] ret_id;
  logic [DW-1:0] ret_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_data;
  logic          read_pending;
  logic          empty;
  logic          unsol_err;
  logic          timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       rv;
    logic [3:0] rid;
    logic [7:0] rdat;
    logic       rr;
    logic       e_ir;
    logic       e_rv;
    logic [3:0] e_id;
    logic [7:0] e_dat;
    logic       e_pend;
    logic       e_empty;
    logic       e_ue;
    logic       e_te;
  } vec_t;

  vec_t vecs[$];

  read_response_fifo #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ret_valid(ret_valid), .ret_id(ret_id), .ret_data(ret_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .read_pending(read_pending), .empty(empty),
    .unsol_err(unsol_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, iv, rv, input logic [3:0] rid, input logic [7:0] rdat,
                     input logic rr, input logic e_ir, e_rv, input logic [3:0] e_id,
                     input logic [7:0] e_dat, input logic e_pend, e_empty, e_ue, e_te);
    vec_t v;
    v.rst = r; v.iv = iv; v.rv = rv; v.rid = rid; v.rdat = rdat; v.rr = rr;
    v.e_ir = e_ir; v.e_rv = e_rv; v.e_id = e_id; v.e_dat = e_dat;
    v.e_pend = e_pend; v.e_empty = e_empty; v.e_ue = e_ue; v.e_te = e_te;
    vecs.push_back(v);
  endtask

  // Apply one cycle of stimulus and sample 1 time unit after the rising edge.
  task automatic step(input logic r, iv, rv, input logic [3:0] rid, input logic [7:0] rdat,
                      input logic rr);
    rst         = r;
    issue_valid = iv;
    ret_valid   = rv;
    ret_id      = rid;
    ret_data    = {120'd0, rdat};
    resp_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  // Flags order: issue_ready, resp_valid, read_pending, empty, unsol_err, timeout_err.
  task automatic check_flags(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {issue_ready, resp_valid, read_pending, empty, unsol_err, timeout_err};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s flags(ir,rv,pend,empty,ue,te): got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic [3:0] id, input logic [7:0] dat);
    logic [DW-1:0] exp_data;
    exp_data = {120'd0, dat};
    n_cmp++;
    if (resp_id !== id || resp_data !== exp_data) begin
      n_fail++;
      $display("FAIL %s head: got id=%h data=%h, want id=%h data=%h",
               name, resp_id, resp_data, id, exp_data);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; ret_valid = 1'b0;
    ret_id = 4'd0; ret_data = {DW{1'b0}}; resp_ready = 1'b0;

    //  rst iv rv rid   rdat  rr | ir rv id    dat   pend empty ue te
    // reset for two cycles
    add(1, 0, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 0, 1, 0, 0);
    // credit exhaustion
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 1, 4'h3, 8'hA5, 0,  0, 1, 4'h3, 8'hA5, 1, 0, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  0, 1, 4'h3, 8'hA5, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(1, 0, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 0, 1, 0, 0);
    // ordering under backpressure
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 4'h1, 8'h11, 0,  0, 1, 4'h1, 8'h11, 1, 0, 0, 0);
    add(0, 0, 1, 4'h2, 8'h22, 0,  0, 1, 4'h1, 8'h11, 1, 0, 0, 0);
    add(0, 0, 1, 4'h3, 8'h33, 0,  0, 1, 4'h1, 8'h11, 1, 0, 0, 0);
    add(0, 0, 1, 4'h4, 8'h44, 0,  0, 1, 4'h1, 8'h11, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 1, 4'h2, 8'h22, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 1, 4'h3, 8'h33, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 1, 4'h4, 8'h44, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 0, 4'h0, 8'h00, 0, 1, 0, 0);
    // build 2 buffered + 2 outstanding, then simultaneous return/pop/issue across the wrap
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 4'h5, 8'h55, 0,  0, 1, 4'h5, 8'h55, 1, 0, 0, 0);
    add(0, 0, 1, 4'h6, 8'h66, 0,  0, 1, 4'h5, 8'h55, 1, 0, 0, 0);
    add(0, 1, 1, 4'h7, 8'h77, 1,  1, 1, 4'h6, 8'h66, 1, 0, 0, 0);
    add(0, 1, 1, 4'h8, 8'h88, 1,  1, 1, 4'h7, 8'h77, 1, 0, 0, 0);
    add(0, 1, 1, 4'h9, 8'h99, 1,  1, 1, 4'h8, 8'h88, 1, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 1, 4'h9, 8'h99, 1, 0, 0, 0);
    add(0, 0, 1, 4'hA, 8'hAA, 1,  1, 1, 4'hA, 8'hAA, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 8'h00, 1,  1, 0, 4'h0, 8'h00, 0, 1, 0, 0);
    // unsolicited return
    add(0, 0, 1, 4'hF, 8'hFF, 0,  1, 0, 4'h0, 8'h00, 0, 1, 1, 0);
    add(0, 0, 0, 4'h0, 8'h00, 0,  1, 0, 4'h0, 8'h00, 0, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].rv, vecs[i].rid, vecs[i].rdat, vecs[i].rr);
      check_flags($sformatf("vec%0d", i),
                  {vecs[i].e_ir, vecs[i].e_rv, vecs[i].e_pend,
                   vecs[i].e_empty, vecs[i].e_ue, vecs[i].e_te});
      if (vecs[i].e_rv) begin
        check_head($sformatf("vec%0d", i), vecs[i].e_id, vecs[i].e_dat);
      end
    end

    // Watchdog, mid-operation reset and late return.
    step(1, 0, 0, 4'h0, 8'h00, 0);
    check_flags("wd_reset", 6'b100100);
    step(0, 1, 0, 4'h0, 8'h00, 0);
    check_flags("wd_issue", 6'b101100);
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 0, 4'h0, 8'h00, 0);
    end
    check_flags("wd_before_expiry", 6'b101100);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 4'h0, 8'h00, 0);
    end
    check_flags("wd_expired", 6'b101101);
    step(1, 0, 0, 4'h0, 8'h00, 0);
    check_flags("wd_midop_reset", 6'b100100);
    step(0, 0, 1, 4'h2, 8'h5A, 0);
    check_flags("late_return", 6'b100110);
    step(0, 0, 0, 4'h0, 8'h00, 0);
    check_flags("late_return_sticky", 6'b100110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
